// File: rtl/ifmap_write_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_write_address_generator
// Function : Write-side pointer keeper for an IFMap scratchpad ring. Accepts
//            a row of words, registers the scratchpad write, and tracks the
//            live window (start_data..end_data) released by the read side.
// Revision : 1.0 - initial release
// ============================================================================
module ifmap_write_address_generator #(
  parameter int IFMAP_ADDR_WIDTH = 4,
  parameter int IFMAP_DEPTH      = 16,
  parameter int STRIDE_WIDTH     = 2,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        din_valid,
  input  logic                        din_last,
  output logic                        din_ready,
  input  logic [STRIDE_WIDTH-1:0]     stride,
  input  logic                        advance,
  input  logic                        row_done,
  input  logic                        clr,
  output logic                        wen,
  output logic [IFMAP_ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [IFMAP_ADDR_WIDTH-1:0] start_data,
  output logic [IFMAP_ADDR_WIDTH-1:0] end_data,
  output logic                        valid_end,
  output logic                        empty,
  output logic                        full
);

  localparam int CNT_W = $clog2(IFMAP_DEPTH + 1);
  // Wide enough for count+1 and start+stride without overflow
  localparam int SUM_W = ((IFMAP_ADDR_WIDTH > CNT_W) ? IFMAP_ADDR_WIDTH : CNT_W)
                         + STRIDE_WIDTH + 1;
  localparam logic [SUM_W-1:0]            DEPTH_S   = SUM_W'(IFMAP_DEPTH);
  localparam logic [CNT_W-1:0]            DEPTH_C   = CNT_W'(IFMAP_DEPTH);
  localparam logic [IFMAP_ADDR_WIDTH-1:0] LAST_ADDR = IFMAP_ADDR_WIDTH'(IFMAP_DEPTH - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                      state_q,     state_d;
  logic [IFMAP_ADDR_WIDTH-1:0] wptr_q,      wptr_d;
  logic [IFMAP_ADDR_WIDTH-1:0] start_q,     start_d;
  logic [IFMAP_ADDR_WIDTH-1:0] end_q,       end_d;
  logic [CNT_W-1:0]            count_q,     count_d;
  logic                        wen_q,       wen_d;
  logic [IFMAP_ADDR_WIDTH-1:0] waddr_q,     waddr_d;
  logic [DATA_WIDTH-1:0]       wdata_q,     wdata_d;
  logic                        valid_end_q, valid_end_d;

  logic                        accept;
  logic [IFMAP_ADDR_WIDTH-1:0] wptr_inc;
  logic [IFMAP_ADDR_WIDTH-1:0] start_adv;
  logic [SUM_W-1:0]            cnt_acc;
  logic [SUM_W-1:0]            stride_s;

  // rst gates ready so nothing is offered while the block is held in reset
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign din_ready = rst & (state_q == FILL) & ~full & ~clr;
  assign accept    = din_valid & din_ready;

  assign wptr_inc  = (wptr_q == LAST_ADDR) ? '0 : wptr_q + IFMAP_ADDR_WIDTH'(1);
  assign cnt_acc   = SUM_W'(count_q) + SUM_W'(accept);
  assign stride_s  = SUM_W'(stride);
  assign start_adv = IFMAP_ADDR_WIDTH'((SUM_W'(start_q) + stride_s) % DEPTH_S);

  // Next-state: clear dominates, then write, then row_done over advance
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    start_d     = start_q;
    end_d       = end_q;
    count_d     = count_q;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    valid_end_d = 1'b0;

    if (clr) begin
      state_d = FILL;
      wptr_d  = '0;
      start_d = '0;
      end_d   = '0;
      count_d = '0;
      waddr_d = '0;
      wdata_d = '0;
    end else begin
      if (accept) begin
        wen_d   = 1'b1;
        waddr_d = wptr_q;
        wdata_d = din;
        end_d   = wptr_q;
        wptr_d  = wptr_inc;
        count_d = CNT_W'(cnt_acc);
      end

      if (row_done) begin
        start_d = wptr_d;
        count_d = '0;
      end else if (advance && (stride != '0)) begin
        // Releasing everything collapses the window onto the write pointer
        if (cnt_acc <= stride_s) begin
          count_d = '0;
          start_d = wptr_d;
        end else begin
          count_d = CNT_W'(cnt_acc - stride_s);
          start_d = start_adv;
        end
      end

      case (state_q)
        FILL:    if (accept && din_last) state_d = HOLD;
        HOLD:    if (row_done)           state_d = FILL;
        default:                         state_d = FILL;
      endcase

      // Lags the HOLD entry by one cycle so the last word is already written
      valid_end_d = (state_q == HOLD) && !row_done;
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wptr_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      count_q     <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      valid_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      count_q     <= count_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      valid_end_q <= valid_end_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign start_data = start_q;
  assign end_data   = end_q;
  assign valid_end  = valid_end_q;

endmodule
`default_nettype wire

// File: tb/tb_ifmap_write_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifmap_write_address_generator
// Function : Self-checking bench: vector table, directed corner sequences and
//            random traffic against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifmap_write_address_generator;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int SW    = 2;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_last = 1'b0;
  logic          din_ready;
  logic [SW-1:0] stride = '0;
  logic          advance = 1'b0;
  logic          row_done = 1'b0;
  logic          clr = 1'b0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] start_data;
  logic [AW-1:0] end_data;
  logic          valid_end;
  logic          empty;
  logic          full;

  ifmap_write_address_generator #(
    .IFMAP_ADDR_WIDTH(AW),
    .IFMAP_DEPTH     (DEPTH),
    .STRIDE_WIDTH    (SW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .stride    (stride),
    .advance   (advance),
    .row_done  (row_done),
    .clr       (clr),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .start_data(start_data),
    .end_data  (end_data),
    .valid_end (valid_end),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: ring of DEPTH entries described by plain integers
  int m_wptr, m_start, m_end, m_count, m_waddr, m_wdata;
  int m_hold, m_ve, m_wen;

  typedef struct {
    int v, d, l, adv, st, rd, c;
    int rdy, wen, waddr, wdata, start, endd, ve, empty, full;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wptr = 0; m_start = 0; m_end = 0; m_count = 0;
    m_waddr = 0; m_wdata = 0; m_hold = 0; m_ve = 0; m_wen = 0;
  endtask

  function automatic int m_ready(input int c);
    return ((m_hold == 0) && (m_count < DEPTH) && (c == 0)) ? 1 : 0;
  endfunction

  task automatic model_step(input int v, input int d, input int l, input int adv,
                            input int st, input int rd, input int c);
    int acc, wp_new, cnt, stn, hold_new;
    acc = (v != 0) ? m_ready(c) : 0;
    if (c != 0) begin
      model_reset();
      return;
    end
    wp_new   = (acc != 0) ? (m_wptr + 1) % DEPTH : m_wptr;
    cnt      = m_count + acc;
    stn      = m_start;
    hold_new = m_hold;
    m_ve     = ((m_hold != 0) && (rd == 0)) ? 1 : 0;
    m_wen    = acc;
    if (acc != 0) begin
      m_waddr = m_wptr;
      m_wdata = d & 255;
      m_end   = m_wptr;
    end
    if (rd != 0) begin
      stn = wp_new; cnt = 0; hold_new = 0;
    end else if ((adv != 0) && (st != 0)) begin
      cnt = cnt - st;
      stn = (stn + st) % DEPTH;
      if (cnt <= 0) begin
        cnt = 0; stn = wp_new;
      end
    end
    if ((acc != 0) && (l != 0)) hold_new = 1;
    m_wptr = wp_new; m_count = cnt; m_start = stn; m_hold = hold_new;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wen"},       wen,        m_wen);
    chk({tag, ".waddr"},     waddr,      m_waddr);
    chk({tag, ".wdata"},     wdata,      m_wdata);
    chk({tag, ".start"},     start_data, m_start);
    chk({tag, ".end"},       end_data,   m_end);
    chk({tag, ".valid_end"}, valid_end,  m_ve);
    chk({tag, ".empty"},     empty,      (m_count == 0) ? 1 : 0);
    chk({tag, ".full"},      full,       (m_count == DEPTH) ? 1 : 0);
  endtask

  // One clock: drive, check ready, step model, clock, check registered outputs
  task automatic cycle(input int v, input int d, input int l, input int adv,
                       input int st, input int rd, input int c,
                       input string tag, output int rdy_seen);
    din_valid = (v != 0);
    din       = DW'(d);
    din_last  = (l != 0);
    advance   = (adv != 0);
    stride    = SW'(st);
    row_done  = (rd != 0);
    clr       = (c != 0);
    #1;
    rdy_seen = din_ready;
    chk({tag, ".din_ready"}, din_ready, m_ready(c));
    model_step(v, d, l, adv, st, rd, c);
    @(posedge clk);
    #1;
    check_model(tag);
    din_valid = 1'b0; din_last = 1'b0; advance = 1'b0;
    row_done  = 1'b0; clr = 1'b0; stride = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".wen"},       wen,        0);
    chk({tag, ".waddr"},     waddr,      0);
    chk({tag, ".wdata"},     wdata,      0);
    chk({tag, ".start"},     start_data, 0);
    chk({tag, ".end"},       end_data,   0);
    chk({tag, ".valid_end"}, valid_end,  0);
    chk({tag, ".empty"},     empty,      1);
    chk({tag, ".full"},      full,       0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy;
    //           v   d   l adv st rd c | rdy wen waddr wdata start end ve empty full
    tbl[0]  = '{1, 170, 0, 0, 0, 0, 0,   1, 1, 0, 170, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 187, 0, 0, 0, 0, 0,   1, 1, 1, 187, 0, 1, 0, 0, 0};
    tbl[2]  = '{0,   0, 0, 1, 1, 0, 0,   1, 0, 1, 187, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 204, 0, 1, 3, 0, 0,   1, 1, 2, 204, 3, 2, 0, 1, 0};
    tbl[4]  = '{1, 221, 1, 0, 0, 0, 0,   1, 1, 3, 221, 3, 3, 0, 0, 0};
    tbl[5]  = '{1, 238, 0, 0, 0, 0, 0,   0, 0, 3, 221, 3, 3, 1, 0, 0};
    tbl[6]  = '{0,   0, 0, 1, 2, 0, 0,   0, 0, 3, 221, 4, 3, 1, 1, 0};
    tbl[7]  = '{0,   0, 0, 0, 0, 1, 0,   0, 0, 3, 221, 4, 3, 0, 1, 0};
    tbl[8]  = '{1,  17, 0, 0, 0, 0, 0,   1, 1, 4,  17, 4, 4, 0, 0, 0};
    tbl[9]  = '{1,  51, 0, 0, 0, 0, 1,   0, 0, 0,   0, 0, 0, 0, 1, 0};
    tbl[10] = '{1,  34, 0, 0, 0, 0, 0,   1, 1, 0,  34, 0, 0, 0, 0, 0};

    model_reset();

    // Reset held: everything at reset values, ready low
    #2;
    check_reset_values("reset");
    chk("reset.din_ready", din_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("release.din_ready", din_ready, 1);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].adv, tbl[i].st, tbl[i].rd, tbl[i].c,
            $sformatf("tbl%0d", i), rdy);
      chk($sformatf("tbl%0d.x_ready", i), rdy,        tbl[i].rdy);
      chk($sformatf("tbl%0d.x_wen", i),   wen,        tbl[i].wen);
      chk($sformatf("tbl%0d.x_waddr", i), waddr,      tbl[i].waddr);
      chk($sformatf("tbl%0d.x_wdata", i), wdata,      tbl[i].wdata);
      chk($sformatf("tbl%0d.x_start", i), start_data, tbl[i].start);
      chk($sformatf("tbl%0d.x_end", i),   end_data,   tbl[i].endd);
      chk($sformatf("tbl%0d.x_ve", i),    valid_end,  tbl[i].ve);
      chk($sformatf("tbl%0d.x_empty", i), empty,      tbl[i].empty);
      chk($sformatf("tbl%0d.x_full", i),  full,       tbl[i].full);
    end

    // 13-beat row, last on 13
    cycle(0, 0, 0, 0, 0, 0, 1, "row13.clr", rdy);
    for (int i = 1; i <= 13; i++) begin
      cycle(1, i, (i == 13) ? 1 : 0, 0, 0, 0, 0, "row13", rdy);
      chk("row13.x_waddr", waddr, i - 1);
      chk("row13.x_wdata", wdata, i);
    end
    chk("row13.x_end", end_data, 12);
    chk("row13.x_start", start_data, 0);
    chk("row13.x_ve_lag", valid_end, 0);
    chk("row13.x_ready", din_ready, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, "row13.hold", rdy);
    chk("row13.x_ve", valid_end, 1);

    // row_done from HOLD, next row continues at 13 and wraps
    cycle(0, 0, 0, 1, 2, 1, 0, "rowdone", rdy);
    chk("rowdone.x_start", start_data, 13);
    chk("rowdone.x_empty", empty, 1);
    chk("rowdone.x_ve", valid_end, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 100 + i, 0, 0, 0, 0, 0, "wrap", rdy);
      chk("wrap.x_waddr", waddr, (13 + i) % DEPTH);
    end

    // Fill to full, stall, then free three entries
    cycle(0, 0, 0, 0, 0, 0, 1, "full.clr", rdy);
    for (int i = 0; i < 16; i++) cycle(1, i, 0, 0, 0, 0, 0, "full.fill", rdy);
    chk("full.x_full", full, 1);
    chk("full.x_ready", din_ready, 0);
    cycle(1, 77, 0, 0, 0, 0, 0, "full.stall", rdy);
    chk("full.x_stall_wen", wen, 0);
    cycle(1, 77, 0, 1, 3, 0, 0, "full.adv", rdy);
    chk("full.x_adv_start", start_data, 3);
    chk("full.x_adv_full", full, 0);
    chk("full.x_adv_wen", wen, 0);
    cycle(1, 77, 0, 0, 0, 0, 0, "full.resume", rdy);
    chk("full.x_resume_wen", wen, 1);
    chk("full.x_resume_waddr", waddr, 0);
    chk("full.x_resume_wdata", wdata, 77);

    // Accept and over-release in the same cycle
    cycle(0, 0, 0, 0, 0, 0, 1, "sat.clr", rdy);
    cycle(1, 5, 0, 0, 0, 0, 0, "sat.b0", rdy);
    cycle(1, 6, 0, 0, 0, 0, 0, "sat.b1", rdy);
    cycle(1, 7, 0, 1, 3, 0, 0, "sat.both", rdy);
    chk("sat.x_empty", empty, 1);
    chk("sat.x_start", start_data, 3);
    chk("sat.x_wen", wen, 1);

    // Async reset pulse mid-row, then clr
    cycle(0, 0, 0, 0, 0, 0, 1, "arst.clr", rdy);
    for (int i = 0; i < 5; i++) cycle(1, 40 + i, 0, 0, 0, 0, 0, "arst.fill", rdy);
    din_valid = 1'b1;
    din = 8'd99;
    rst = 1'b0;
    #1;
    check_reset_values("arst.low");
    chk("arst.low.din_ready", din_ready, 0);
    rst = 1'b1;
    din_valid = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, "arst.after", rdy);
    chk("arst.x_no_wen", wen, 0);
    cycle(1, 60, 0, 0, 0, 0, 0, "clr.b0", rdy);
    cycle(1, 61, 1, 0, 0, 0, 0, "clr.b1", rdy);
    cycle(1, 62, 0, 1, 1, 0, 1, "clr.go", rdy);
    check_reset_values("clr.x");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int rv, rl, ra, rs, rr, rc;
      rv = ($urandom_range(0, 9) < 7) ? 1 : 0;
      rl = ($urandom_range(0, 9) == 0) ? 1 : 0;
      ra = ($urandom_range(0, 9) < 3) ? 1 : 0;
      rs = $urandom_range(0, 3);
      rr = ($urandom_range(0, 19) == 0) ? 1 : 0;
      rc = ($urandom_range(0, 49) == 0) ? 1 : 0;
      cycle(rv, $urandom_range(0, 255), rl, ra, rs, rr, rc, "rnd", rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
